// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one asynchronous 4-phase bundled-data adder among NREQ clocked requesters.
// Optional watchdog: define ADDER_ARB_TIMEOUT_EN to build the TIMEOUT counter behind err_o.
module adder_share_arb #(
  parameter int WIDTH   = 13,
  parameter int NREQ    = 4,
  parameter int SYNC    = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      sum_o,
  output logic                  add_req,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic                  add_ack,
  input  logic                  sum_req,
  input  logic [WIDTH-1:0]      sum_data,
  output logic                  sum_ack,
  output logic                  err_o,
  output logic [2:0]            dbgState
);
  // Every port is 4-phase: a request level rises, its acknowledge rises, the request falls,
  // then the acknowledge falls; data is bundled with (and stable under) the request level.
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_SUM, DRAIN, RESP} state_t;
  state_t state, stateNext;

  logic [SYNC-1:0]  addAckSync, sumReqSync;
  logic             addAckS, sumReqS;
  logic [GW-1:0]    grant, lastGrant, winner, idx;
  logic             found;
  logic [WIDTH-1:0] winA, winB;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addAckSync <= '0;
      sumReqSync <= '0;
    end else begin
      addAckSync <= {addAckSync[SYNC-2:0], add_ack};
      sumReqSync <= {sumReqSync[SYNC-2:0], sum_req};
    end
  end

  assign addAckS  = addAckSync[SYNC-1];
  assign sumReqS  = sumReqSync[SYNC-1];
  assign dbgState = state;

  // Search starts one past the last completed grant, so a fresh reset favours requester 0.
  always_comb begin
    found  = 1'b0;
    winner = lastGrant;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = GW'((int'(lastGrant) + k) % NREQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    winA = '0;
    winB = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == GW'(i)) begin
        winA = op_a[i*WIDTH +: WIDTH];
        winB = op_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (found) stateNext = SEND;
      SEND:     if (addAckS) stateNext = WAIT_SUM;
      WAIT_SUM: if (sumReqS) stateNext = DRAIN;
      DRAIN:    if (!sumReqS && !addAckS) stateNext = RESP;
      RESP:     if ((req & ack) == '0) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // sum_data is only sampled once the synchronized sum_req says it has settled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant     <= '0;
      lastGrant <= GW'(NREQ - 1);
      add_a     <= '0;
      add_b     <= '0;
      add_req   <= 1'b0;
      sum_o     <= '0;
      sum_ack   <= 1'b0;
      ack       <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          grant   <= winner;
          add_a   <= winA;
          add_b   <= winB;
          add_req <= 1'b1;
        end
        SEND: if (addAckS) add_req <= 1'b0;
        WAIT_SUM: if (sumReqS) begin
          sum_o   <= sum_data;
          sum_ack <= 1'b1;
        end
        DRAIN: if (!sumReqS && !addAckS) begin
          sum_ack   <= 1'b0;
          ack       <= NREQ'(1) << grant;
          lastGrant <= grant;
        end
        RESP: if ((req & ack) == '0) ack <= '0;
        default: ;
      endcase
    end
  end

`ifdef ADDER_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wdCnt;
  logic          errR;

  // Counts only while the adder owes us something; the FSM is never forced out of a stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdCnt <= '0;
      errR  <= 1'b0;
    end else begin
      if (state == IDLE) wdCnt <= '0;
      else if (state != RESP && wdCnt != CW'(TIMEOUT)) wdCnt <= wdCnt + 1'b1;
      if (wdCnt == CW'(TIMEOUT)) errR <= 1'b1;
    end
  end

  assign err_o = errR;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: behavioural 4-phase adder, requester driver, round-robin reference model.
module tb_adder_share_arb;
  localparam int W = 13;
  localparam int N = 4;
`ifdef ADDER_ARB_TIMEOUT_EN
  localparam int TOUT = 16;
`else
  localparam int TOUT = 256;
`endif

  logic clk, reset;
  logic [N-1:0] req, ack;
  logic [N*W-1:0] opA, opB;
  logic [W-1:0] sum_o, add_a, add_b, sum_data;
  logic add_req, add_ack, sum_req, sum_ack, err_o;
  logic [2:0] dbgState;

  adder_share_arb #(.WIDTH(W), .NREQ(N), .SYNC(2), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .op_a(opA), .op_b(opB), .ack(ack), .sum_o(sum_o),
    .add_req(add_req), .add_a(add_a), .add_b(add_b), .add_ack(add_ack), .sum_req(sum_req),
    .sum_data(sum_data), .sum_ack(sum_ack), .err_o(err_o), .dbgState(dbgState)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural adder environment ----------------
  int adPh, adDly, maxDly;
  bit noSum, noAck, randomRaise;
  logic [W-1:0] capA, capB;

  always @(negedge clk) begin
    if (!reset || noAck) begin
      add_ack = 1'b0;
      sum_req = 1'b0;
      adPh = 0;
    end else begin
      case (adPh)
        0: if (add_req) begin
          capA = add_a; capB = add_b;
          adDly = $urandom_range(0, maxDly);
          adPh = 1;
        end
        1: if (adDly == 0) begin
          add_ack = 1'b1;
          adDly = $urandom_range(0, maxDly);
          adPh = 2;
        end else adDly--;
        2: if (!noSum) begin
          if (adDly == 0) begin
            sum_data = capA + capB;
            sum_req = 1'b1;
            adPh = 3;
          end else adDly--;
        end
        3: if (sum_ack) begin
          sum_req = 1'b0;
          sum_data = W'($urandom);
          adPh = 4;
        end
        default: if (!add_req) begin
          add_ack = 1'b0;
          adPh = 0;
        end
      endcase
    end
  end

  // ---------------- observation / driver ----------------
  typedef struct { logic [N-1:0] reqSnap; logic [N*W-1:0] a; logic [N*W-1:0] b; } grant_t;
  typedef struct { logic [N-1:0] ackVec; logic [W-1:0] sum; int cyc; } resp_t;
  grant_t grantQ[$];
  resp_t respQ[$];
  logic [W-1:0] obsA_q[$], obsB_q[$], expA_q[$], expB_q[$], exp_q[$];
  int expWin_q[$];
  int tests, fails, cyc, rrPtr;
  int left[N];
  bit prevAddReq;
  logic [N-1:0] sampledReq;
  logic [N*W-1:0] sampledA, sampledB;

  always @(posedge clk) begin
    sampledReq <= req;
    sampledA <= opA;
    sampledB <= opB;
  end

  task automatic clear_logs();
    grantQ.delete(); respQ.delete(); obsA_q.delete(); obsB_q.delete();
    expA_q.delete(); expB_q.delete(); exp_q.delete(); expWin_q.delete();
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (add_req && !prevAddReq) begin
      grantQ.push_back('{sampledReq, sampledA, sampledB});
      obsA_q.push_back(add_a);
      obsB_q.push_back(add_b);
    end
    prevAddReq = add_req;
    for (int i = 0; i < N; i++) begin
      if (req[i] && ack[i]) begin
        respQ.push_back('{ack, sum_o, cyc});
        req[i] = 1'b0;
      end else if (!req[i] && !ack[i] && left[i] > 0 && (!randomRaise || $urandom_range(0, 2) == 0)) begin
        left[i]--;
        opA[i*W +: W] = W'($urandom);
        opB[i*W +: W] = W'($urandom);
        req[i] = 1'b1;
      end
    end
  endtask

  task automatic run_until(input int n, input int budget, output bit ok);
    int b;
    b = 0;
    while (respQ.size() < n && b < budget) begin
      cycle();
      b++;
    end
    ok = (respQ.size() >= n);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0;
    noSum = 1'b0;
    noAck = 1'b0;
    prevAddReq = 1'b0;
    rrPtr = N - 1;
    for (int i = 0; i < N; i++) left[i] = 0;
    clear_logs();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cycle();
  endtask

  // Reference: each grant goes to the first requester at/after pointer+1 among those requesting
  // when the grant was made; the result is the modulo-2^W sum of that requester's operands.
  task automatic model_grants();
    grant_t g;
    int w;
    logic [N*W-1:0] sa, sb;
    while (grantQ.size() > 0) begin
      g = grantQ.pop_front();
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && g.reqSnap[(rrPtr + k) % N]) w = (rrPtr + k) % N;
      if (w >= 0) begin
        rrPtr = w;
        sa = g.a >> (w * W);
        sb = g.b >> (w * W);
      end else begin
        sa = '0;
        sb = '0;
      end
      expWin_q.push_back(w);
      expA_q.push_back(sa[W-1:0]);
      expB_q.push_back(sb[W-1:0]);
      exp_q.push_back(W'(sa[W-1:0] + sb[W-1:0]));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (ack !== '0 || add_req !== 1'b0 || sum_ack !== 1'b0) begin
      fails++; $display("FAIL reset_handshake: ack=%b add_req=%b sum_ack=%b, expected 0/0/0", ack, add_req, sum_ack);
    end
    tests++;
    if (sum_o !== '0 || add_a !== '0 || add_b !== '0) begin
      fails++; $display("FAIL reset_data: sum_o=%0d add_a=%0d add_b=%0d, expected 0", sum_o, add_a, add_b);
    end
    tests++;
    if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err: err_o=%b, expected 0", err_o); end
    reset = 1'b1;
    cycle(); cycle();
    tests++;
    if (add_req !== 1'b0 || ack !== '0) begin
      fails++; $display("FAIL idle_after_reset: add_req=%b ack=%b, expected 0", add_req, ack);
    end
  endtask

  task automatic test_single();
    bit ok;
    int t0;
    maxDly = 0; randomRaise = 1'b0; clear_logs();
    cycle();
    opA[0 +: W] = 13'd14; opB[0 +: W] = 13'd5; req[0] = 1'b1; t0 = cyc;
    cycle();
    tests++;
    if (add_req !== 1'b1) begin fails++; $display("FAIL single_add_req_latency: add_req=%b, expected 1", add_req); end
    run_until(1, 60, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL single_no_ack: got %0d responses, expected 1", respQ.size()); return; end
    model_grants();
    tests++;
    if (respQ[0].sum !== 13'd19) begin fails++; $display("FAIL single_sum: got %0d, expected 19", respQ[0].sum); end
    tests++;
    if (respQ[0].ackVec !== 4'b0001) begin fails++; $display("FAIL single_ack: got %b, expected 0001", respQ[0].ackVec); end
    tests++;
    if (respQ[0].cyc - t0 != 10) begin fails++; $display("FAIL single_latency: got %0d cycles, expected 10", respQ[0].cyc - t0); end
    tests++;
    if (obsA_q[0] !== expA_q[0] || obsB_q[0] !== expB_q[0]) begin
      fails++; $display("FAIL single_operands: add_a=%0d add_b=%0d, expected %0d %0d", obsA_q[0], obsB_q[0], expA_q[0], expB_q[0]);
    end
    cycle();
    tests++;
    if (ack !== '0 || add_req !== 1'b0 || sum_ack !== 1'b0) begin
      fails++; $display("FAIL single_release: ack=%b add_req=%b sum_ack=%b, expected all 0", ack, add_req, sum_ack);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    maxDly = 2; clear_logs();
    cycle();
    opA[W +: W] = 13'd8191; opB[W +: W] = 13'd1; req[1] = 1'b1;
    run_until(1, 80, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL overflow_no_ack: got %0d responses, expected 1", respQ.size()); return; end
    model_grants();
    tests++;
    if (respQ[0].sum !== 13'd0) begin fails++; $display("FAIL overflow_sum: got %0d, expected 0", respQ[0].sum); end
    tests++;
    if (respQ[0].ackVec !== 4'b0010 || expWin_q[0] != 1) begin
      fails++; $display("FAIL overflow_ack: got %b (model winner %0d), expected 0010", respQ[0].ackVec, expWin_q[0]);
    end
    cycle(); cycle();
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [N-1:0] order[4];
    logic [N-1:0] ev;
    order = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    do_reset();
    maxDly = 2; randomRaise = 1'b0;
    left[0] = 2; left[2] = 2;
    run_until(4, 200, ok);
    model_grants();
    tests++;
    if (!ok || expWin_q.size() < 4) begin
      fails++; $display("FAIL simul_count: responses=%0d grants=%0d, expected 4", respQ.size(), expWin_q.size()); return;
    end
    for (int t = 0; t < 4; t++) begin
      ev = (expWin_q[t] >= 0) ? N'(1) << expWin_q[t] : '0;
      tests++;
      if (respQ[t].ackVec !== ev || respQ[t].ackVec !== order[t]) begin
        fails++; $display("FAIL simul_order[%0d]: ack=%b, expected %b", t, respQ[t].ackVec, order[t]);
      end
      tests++;
      if (obsA_q[t] !== expA_q[t] || respQ[t].sum !== exp_q[t]) begin
        fails++; $display("FAIL simul_data[%0d]: add_a=%0d sum=%0d, expected %0d %0d", t, obsA_q[t], respQ[t].sum, expA_q[t], exp_q[t]);
      end
    end
  endtask

  task automatic test_fairness();
    bit ok;
    logic [N-1:0] ev;
    do_reset();
    maxDly = 1; randomRaise = 1'b0;
    for (int i = 0; i < N; i++) left[i] = 2;
    run_until(8, 400, ok);
    model_grants();
    tests++;
    if (!ok || expWin_q.size() < 8) begin
      fails++; $display("FAIL fair_count: responses=%0d grants=%0d, expected 8", respQ.size(), expWin_q.size()); return;
    end
    for (int t = 0; t < 8; t++) begin
      ev = N'(1) << (t % N);
      tests++;
      if (respQ[t].ackVec !== ev || expWin_q[t] != t % N) begin
        fails++; $display("FAIL fair_order[%0d]: ack=%b model=%0d, expected %b", t, respQ[t].ackVec, expWin_q[t], ev);
      end
      tests++;
      if (respQ[t].sum !== exp_q[t] || obsB_q[t] !== expB_q[t]) begin
        fails++; $display("FAIL fair_data[%0d]: sum=%0d add_b=%0d, expected %0d %0d", t, respQ[t].sum, obsB_q[t], exp_q[t], expB_q[t]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    logic [N-1:0] ev;
    clear_logs();
    maxDly = 3; randomRaise = 1'b1; n = 0;
    cycle(); cycle();
    for (int i = 0; i < N; i++) begin left[i] = $urandom_range(1, 3); n += left[i]; end
    run_until(n, 60 * n, ok);
    model_grants();
    tests++;
    if (!ok || expWin_q.size() < n) begin
      fails++; $display("FAIL random_count: responses=%0d grants=%0d, expected %0d", respQ.size(), expWin_q.size(), n); return;
    end
    for (int t = 0; t < n; t++) begin
      ev = (expWin_q[t] >= 0) ? N'(1) << expWin_q[t] : '0;
      tests++;
      if (respQ[t].ackVec !== ev || respQ[t].sum !== exp_q[t] || obsA_q[t] !== expA_q[t]) begin
        fails++; $display("FAIL random_txn[%0d]: ack=%b sum=%0d add_a=%0d, expected %b %0d %0d",
                          t, respQ[t].ackVec, respQ[t].sum, obsA_q[t], ev, exp_q[t], expA_q[t]);
      end
    end
`ifndef ADDER_ARB_TIMEOUT_EN
    tests++;
    if (err_o !== 1'b0) begin fails++; $display("FAIL random_err: err_o=%b, expected 0", err_o); end
`endif
    randomRaise = 1'b0;
    cycle(); cycle();
  endtask

  task automatic test_reset_mid();
    bit ok, seenHigh, inWait;
    clear_logs();
    maxDly = 1; noSum = 1'b1; randomRaise = 1'b0;
    left[1] = 1;
    seenHigh = 1'b0; inWait = 1'b0;
    for (int i = 0; i < 60 && !inWait; i++) begin
      cycle();
      if (add_req) seenHigh = 1'b1;
      else if (seenHigh) inWait = 1'b1;
    end
    tests++;
    if (!inWait) begin fails++; $display("FAIL mid_reach_wait: add_req never completed its phase, expected it to"); end
    cycle(); cycle();
    #2 reset = 1'b0;
    #1;
    tests++;
    if (ack !== '0 || add_req !== 1'b0 || sum_ack !== 1'b0 || err_o !== 1'b0) begin
      fails++; $display("FAIL mid_reset_ctrl: ack=%b add_req=%b sum_ack=%b err_o=%b, expected all 0", ack, add_req, sum_ack, err_o);
    end
    tests++;
    if (sum_o !== '0 || add_a !== '0 || add_b !== '0) begin
      fails++; $display("FAIL mid_reset_data: sum_o=%0d add_a=%0d add_b=%0d, expected 0", sum_o, add_a, add_b);
    end
    do_reset();
    left[3] = 1;
    run_until(1, 80, ok);
    model_grants();
    tests++;
    if (!ok || expWin_q.size() < 1) begin
      fails++; $display("FAIL mid_recover: responses=%0d grants=%0d, expected 1", respQ.size(), expWin_q.size()); return;
    end
    tests++;
    if (respQ[0].ackVec !== 4'b1000 || respQ[0].sum !== exp_q[0]) begin
      fails++; $display("FAIL mid_recover_txn: ack=%b sum=%0d, expected 1000 %0d", respQ[0].ackVec, respQ[0].sum, exp_q[0]);
    end
  endtask

`ifdef ADDER_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    do_reset();
    noAck = 1'b1; randomRaise = 1'b0;
    opA[0 +: W] = 13'd3; opB[0 +: W] = 13'd4; req[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      cycle();
      seen = add_req;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL timeout_no_add_req: add_req=%b, expected 1", add_req); end
    repeat (16) cycle();
    tests++;
    if (err_o !== 1'b0) begin fails++; $display("FAIL timeout_early: err_o=%b at cycle 16, expected 0", err_o); end
    cycle();
    tests++;
    if (err_o !== 1'b1) begin fails++; $display("FAIL timeout_err: err_o=%b at cycle 17, expected 1", err_o); end
    tests++;
    if (add_req !== 1'b1) begin fails++; $display("FAIL timeout_hold: add_req=%b, expected 1", add_req); end
  endtask
`endif

  initial begin
    reset = 1'b0; req = '0; opA = '0; opB = '0;
    add_ack = 1'b0; sum_req = 1'b0; sum_data = '0;
    tests = 0; fails = 0; cyc = 0; rrPtr = N - 1; maxDly = 0;
    noSum = 1'b0; noAck = 1'b0; randomRaise = 1'b0; prevAddReq = 1'b0;
    for (int i = 0; i < N; i++) left[i] = 0;
    test_reset();
    test_single();
    test_overflow();
    test_simultaneous();
    test_fairness();
    test_random();
    test_reset_mid();
`ifdef ADDER_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation still running at %0t, expected completion", $time);
    $fatal(1, "time limit");
  end

endmodule
